// File: rtl/gpio_in_filter.sv
// Pad-input conditioning: per-pin synchronizer, per-pin glitch filter, registered change pulses.
// Optional shared sample prescaler built when GPIO_IN_FILTER_PRESCALER_EN is defined; otherwise every clock is a sample tick.
module gpio_in_filter #(
    parameter int unsigned NUM_PINS    = 256,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] pad_in,
    input  logic [NUM_PINS-1:0] filt_en,
    input  logic [CNT_W-1:0]    filt_len,
    input  logic [15:0]         prescale,
    output logic [NUM_PINS-1:0] gpio_in_data,
    output logic [NUM_PINS-1:0] in_change
);

    localparam int unsigned PS_W = 16;

    logic [NUM_PINS-1:0] sync_r [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_q;
    logic [NUM_PINS-1:0] gpio_in_data_next;
    logic [CNT_W-1:0]    len_m1;
    logic                tick;

    // Synchronizer chain; stage 0 is the only flop that sees the raw pad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r[0] <= '0;
        end else begin
            sync_r[0] <= pad_in;
        end
    end

    for (genvar s = 1; s < SYNC_STAGES; s++) begin : g_sync
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_r[s] <= '0;
            end else begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_q = sync_r[SYNC_STAGES-1];

`ifdef GPIO_IN_FILTER_PRESCALER_EN
    logic [PS_W-1:0] ps_cnt_q;
    logic [PS_W-1:0] ps_cnt_d;

    // Counter wraps at prescale; a count above a freshly lowered prescale wraps without ticking.
    always_comb begin
        ps_cnt_d = ps_cnt_q + PS_W'(1);
        if (ps_cnt_q >= prescale) begin
            ps_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end

    assign tick = (ps_cnt_q == prescale);
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = 1'b1;
`endif

    // filt_len of 0 behaves as 1, so the threshold is max(filt_len,1)-1.
    assign len_m1 = (filt_len == '0) ? '0 : filt_len - CNT_W'(1);

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             dat_d;

        // Counter saturates at the threshold by construction; >= lets a lowered length take effect at once.
        always_comb begin
            cnt_d = cnt_q;
            dat_d = gpio_in_data[p];
            if (!filt_en[p]) begin
                cnt_d = '0;
                dat_d = sync_q[p];
            end else if (tick) begin
                if (sync_q[p] == gpio_in_data[p]) begin
                    cnt_d = '0;
                end else if (cnt_q >= len_m1) begin
                    cnt_d = '0;
                    dat_d = sync_q[p];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign gpio_in_data_next[p] = dat_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_in_data <= '0;
            in_change    <= '0;
        end else begin
            gpio_in_data <= gpio_in_data_next;
            in_change    <= gpio_in_data_next ^ gpio_in_data;
        end
    end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: expectations queued per clock edge, compared at the falling edge.
module tb_gpio_in_filter;

    localparam int unsigned N  = 256;
    localparam int unsigned CW = 8;
    localparam logic [N-1:0] PAT = {192'h0, 64'h90abcdef00000000};
    localparam logic [N-1:0] LO  = {{128{1'b0}}, {128{1'b1}}};
    localparam logic [N-1:0] HI  = {{128{1'b1}}, {128{1'b0}}};

    typedef struct packed {
        int           cyc;
        logic [N-1:0] data;
        logic [N-1:0] chg;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [N-1:0]  pad_in;
    logic [N-1:0]  filt_en;
    logic [CW-1:0] filt_len;
    logic [15:0]   prescale;
    logic [N-1:0]  gpio_in_data;
    logic [N-1:0]  in_change;

    exp_t  sb[$];
    string tags[$];
    int    edge_n  = 0;
    int    base    = 0;
    int    n_tests = 0;
    int    n_fail  = 0;

    gpio_in_filter #(
        .NUM_PINS   (N),
        .SYNC_STAGES(2),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_in      (pad_in),
        .filt_en     (filt_en),
        .filt_len    (filt_len),
        .prescale    (prescale),
        .gpio_in_data(gpio_in_data),
        .in_change   (in_change)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [N-1:0] bit_at(input int p);
        logic [N-1:0] one;
        one = '0;
        one[0] = 1'b1;
        return one << p;
    endfunction

    task automatic mark();
        base = edge_n;
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int rel, input logic [N-1:0] d, input logic [N-1:0] c);
        exp_t e;
        e.cyc  = (rel < 0) ? -1 : base + rel;
        e.data = d;
        e.chg  = c;
        sb.push_back(e);
        tags.push_back(tag);
    endtask

    task automatic compare(input exp_t e, input string tag, input bit on_time);
        n_tests++;
        assert (on_time && gpio_in_data === e.data && in_change === e.chg) else begin
            n_fail++;
            $error("FAIL %s: edge %0d (due %0d) data=%h chg=%h, expected data=%h chg=%h",
                   tag, edge_n, e.cyc, gpio_in_data, in_change, e.data, e.chg);
        end
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        e = sb.pop_front();
        t = tags.pop_front();
        compare(e, t, 1'b1);
    endtask

    // Scoreboard drain: every entry due at this edge is compared away from the rising edge.
    always @(negedge clk) begin
        exp_t  e;
        string t;
        while (sb.size() > 0 && sb[0].cyc >= 0 && sb[0].cyc <= edge_n) begin
            e = sb.pop_front();
            t = tags.pop_front();
            compare(e, t, e.cyc == edge_n);
        end
    end

    initial begin
        rst      = 1'b1;
        pad_in   = '0;
        filt_en  = '0;
        filt_len = '0;
        prescale = '0;
        adv(2);
        push("rst_init", -1, '0, '0);
        check_now();
        rst = 1'b0;
        mark();
        push("post_rst1", 1, '0, '0);
        push("post_rst2", 2, '0, '0);
        adv(3);

        // bypass
        mark();
        pad_in = PAT;
        push("byp_e2", 2, '0, '0);
        push("byp_e3", 3, PAT, PAT);
        push("byp_e4", 4, PAT, '0);
        adv(4);
        mark();
        pad_in = '0;
        push("byp_fall", 3, '0, PAT);
        push("byp_fall_e4", 4, '0, '0);
        adv(5);

        // glitch of 3 clocks with filt_len 4 never reaches the output
        filt_en  = '1;
        filt_len = CW'(4);
        prescale = 16'd0;
        adv(2);
        mark();
        pad_in = bit_at(40);
        for (int k = 1; k <= 8; k++) push("glitch", k, '0, '0);
        adv(3);
        pad_in = '0;
        adv(6);

        // held 4 clocks: rises at edge 6, then falls back after 4 low samples
        mark();
        pad_in = bit_at(40);
        push("hold_e5", 5, '0, '0);
        push("hold_e6", 6, bit_at(40), bit_at(40));
        push("hold_e7", 7, bit_at(40), '0);
        push("hold_e9", 9, bit_at(40), '0);
        push("hold_fall", 10, '0, bit_at(40));
        push("hold_e11", 11, '0, '0);
        adv(4);
        pad_in = '0;
        adv(8);

        // filt_len 0 behaves as 1
        filt_len = CW'(0);
        mark();
        pad_in = bit_at(41);
        push("len0_e2", 2, '0, '0);
        push("len0_e3", 3, bit_at(41), bit_at(41));
        push("len0_e4", 4, bit_at(41), '0);
        adv(4);
        mark();
        pad_in = '0;
        push("len0_fall", 3, '0, bit_at(41));
        adv(4);

        // lower filt_len 10 -> 2 with counter at 5
        filt_len = CW'(10);
        mark();
        pad_in = bit_at(42);
        push("lower_e7", 7, '0, '0);
        push("lower_e8", 8, bit_at(42), bit_at(42));
        push("lower_e9", 9, bit_at(42), '0);
        adv(7);
        filt_len = CW'(2);
        adv(3);
        mark();
        filt_len = CW'(1);
        pad_in   = '0;
        push("lower_fall", 3, '0, bit_at(42));
        adv(4);

        // filt_en dropped mid-count
        filt_len = CW'(8);
        mark();
        pad_in = bit_at(43);
        push("fen_e5", 5, '0, '0);
        push("fen_e6", 6, bit_at(43), bit_at(43));
        push("fen_e7", 7, bit_at(43), '0);
        adv(5);
        filt_en[43] = 1'b0;
        adv(3);
        mark();
        filt_en[43] = 1'b1;
        filt_len    = CW'(1);
        pad_in      = '0;
        push("fen_fall", 3, '0, bit_at(43));
        adv(4);

`ifdef GPIO_IN_FILTER_PRESCALER_EN
        // prescale 9, filt_len 3: phase aligned by holding prescale at 0 first
        prescale = 16'd0;
        filt_len = CW'(3);
        adv(2);
        mark();
        prescale = 16'd9;
        pad_in   = bit_at(64);
        push("ps_e10", 10, '0, '0);
        push("ps_e20", 20, '0, '0);
        push("ps_e29", 29, '0, '0);
        push("ps_rise", 30, bit_at(64), bit_at(64));
        push("ps_e31", 31, bit_at(64), '0);
        adv(32);
        mark();
        prescale = 16'd0;
        filt_len = CW'(1);
        pad_in   = '0;
        push("ps_fall", 3, '0, bit_at(64));
        adv(4);
`else
        // prescale ignored: filt_len 3 lands at edge 5 as with prescale 0
        prescale = 16'd100;
        filt_len = CW'(3);
        mark();
        pad_in = bit_at(64);
        push("ps_off_e4", 4, '0, '0);
        push("ps_off_rise", 5, bit_at(64), bit_at(64));
        push("ps_off_e6", 6, bit_at(64), '0);
        adv(7);
        mark();
        pad_in = '0;
        push("ps_off_fall", 5, '0, bit_at(64));
        adv(6);
        prescale = 16'd0;
`endif

        // async reset with pins high and filter counters part-way
        filt_en  = HI;
        filt_len = CW'(10);
        prescale = 16'd0;
        mark();
        pad_in = '1;
        push("rst_byp", 3, LO, LO);
        push("rst_e5", 5, LO, '0);
        adv(5);
        #5;
        rst = 1'b1;
        #1;
        push("rst_async", -1, '0, '0);
        check_now();
        adv(2);
        rst = 1'b0;
        mark();
        push("rel_e1", 1, '0, '0);
        push("rel_e2", 2, '0, '0);
        push("rel_e3", 3, LO, LO);
        push("rel_e11", 11, LO, '0);
        push("rel_e12", 12, '1, HI);
        push("rel_e13", 13, '1, '0);
        adv(14);

        adv(2);
        n_tests++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
